// File: rtl/uart_alu_runner.sv
// UART-attached command runner: 8N1 receiver, packet parser, ECHO and 32-bit ADD/MUL/DIV,
// with a small TX FIFO feeding an 8N1 transmitter that sends back-to-back frames.
`timescale 1ns/1ps
module uart_alu_runner #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  output logic tx_o
);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
  localparam logic [2:0] P_IDLE = 3'd0, P_RESERVED = 3'd1, P_LEN_LSB = 3'd2, P_LEN_MSB = 3'd3,
                         P_PAYLOAD = 3'd4, P_COMPUTE = 3'd5, P_RESPOND = 3'd6;

  // ---------------- receiver ----------------
  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_valid;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_meta  <= rx_i;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          // Edge, not level: a line held low after a framing error must not retrigger.
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else rx_cnt <= rx_cnt + 1'b1;
        end
        default: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end
          end else rx_cnt <= rx_cnt + 1'b1;
        end
      endcase
    end
  end

  // ---------------- TX FIFO ----------------
  // Handshake: fifo_push is valid and !fifo_full is ready; a byte is written on a cycle
  // where both hold. tx_pop is asserted only when !fifo_empty and consumes the head byte.
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       fifo_full, fifo_empty, fifo_push, tx_pop;
  logic [7:0] fifo_din;

  assign fifo_full  = (fifo_cnt == 3'd4);
  assign fifo_empty = (fifo_cnt == 3'd0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) begin
        fifo_mem[wr_ptr] <= fifo_din;
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (tx_pop) rd_ptr <= rd_ptr + 2'd1;
      case ({fifo_push, tx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;

  // Popping at the end of the stop bit lets the next start bit follow with no idle gap.
  assign tx_pop = !fifo_empty &&
                  ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == BIT_END));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (tx_pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        TX_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state <= TX_STOP;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
        default: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= fifo_mem[rd_ptr];
              tx_state <= TX_START;
            end else tx_state <= TX_IDLE;
          end else tx_cnt <= tx_cnt + 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    tx_o = 1'b1;
    case (tx_state)
      TX_START: tx_o = 1'b0;
      TX_DATA:  tx_o = tx_shift[0];
      default:  tx_o = 1'b1;
    endcase
  end

  // ---------------- parser and ALU ----------------
  logic [2:0]  p_state;
  logic [7:0]  opcode;
  logic [15:0] len, pay_cnt;
  logic [31:0] op_a, op_b, result, mul_lo;
  logic [1:0]  resp_idx;
  logic        div_busy, div_ge;
  logic [4:0]  div_cnt;
  logic [31:0] div_q, div_r, div_next_r;
  logic [32:0] div_shift, div_diff;
  logic        is_alu;

  assign is_alu     = (opcode == OP_ADD) || (opcode == OP_MUL) || (opcode == OP_DIV);
  assign mul_lo     = op_a * op_b;
  assign div_shift  = {div_r, div_q[31]};
  assign div_diff   = div_shift - {1'b0, op_b};
  assign div_ge     = (div_shift >= {1'b0, op_b});
  // The remainder stays below B, so it always fits back into 32 bits.
  assign div_next_r = div_ge ? div_diff[31:0] : div_shift[31:0];

  always_comb begin
    fifo_push = 1'b0;
    fifo_din  = '0;
    if (p_state == P_PAYLOAD && rx_valid && opcode == OP_ECHO && !fifo_full) begin
      fifo_push = 1'b1;
      fifo_din  = rx_byte;
    end else if (p_state == P_RESPOND && !fifo_full) begin
      fifo_push = 1'b1;
      fifo_din  = result[{resp_idx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      p_state  <= P_IDLE;
      opcode   <= '0;
      len      <= '0;
      pay_cnt  <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      resp_idx <= '0;
      div_busy <= 1'b0;
      div_cnt  <= '0;
      div_q    <= '0;
      div_r    <= '0;
    end else begin
      case (p_state)
        P_IDLE: if (rx_valid) begin
          opcode  <= rx_byte;
          op_a    <= '0;
          op_b    <= '0;
          p_state <= P_RESERVED;
        end
        P_RESERVED: if (rx_valid) p_state <= P_LEN_LSB;
        P_LEN_LSB: if (rx_valid) begin
          len[7:0] <= rx_byte;
          p_state  <= P_LEN_MSB;
        end
        P_LEN_MSB: if (rx_valid) begin
          len[15:8] <= rx_byte;
          pay_cnt   <= '0;
          p_state   <= ({rx_byte, len[7:0]} == 16'd0) ? P_IDLE : P_PAYLOAD;
        end
        P_PAYLOAD: if (rx_valid) begin
          if (is_alu && pay_cnt < 16'd8) begin
            if (!pay_cnt[2]) op_a[{pay_cnt[1:0], 3'b000} +: 8] <= rx_byte;
            else             op_b[{pay_cnt[1:0], 3'b000} +: 8] <= rx_byte;
          end
          pay_cnt <= pay_cnt + 16'd1;
          if (pay_cnt == len - 16'd1) begin
            p_state  <= is_alu ? P_COMPUTE : P_IDLE;
            div_busy <= 1'b0;
            resp_idx <= '0;
          end
        end
        P_COMPUTE: begin
          if (opcode == OP_ADD) begin
            result  <= op_a + op_b;
            p_state <= P_RESPOND;
          end else if (opcode == OP_MUL) begin
            result  <= mul_lo;
            p_state <= P_RESPOND;
          end else if (!div_busy) begin
            if (op_b == 32'd0) begin
              result  <= 32'hFFFF_FFFF;
              p_state <= P_RESPOND;
            end else begin
              div_busy <= 1'b1;
              div_q    <= op_a;
              div_r    <= '0;
              div_cnt  <= '0;
            end
          end else begin
            // One restoring step per cycle: shift in the next dividend bit, subtract if it fits.
            div_r   <= div_next_r;
            div_q   <= {div_q[30:0], div_ge};
            div_cnt <= div_cnt + 5'd1;
            if (div_cnt == 5'd31) begin
              result   <= {div_q[30:0], div_ge};
              div_busy <= 1'b0;
              p_state  <= P_RESPOND;
            end
          end
        end
        P_RESPOND: if (!fifo_full) begin
          resp_idx <= resp_idx + 2'd1;
          if (resp_idx == 2'd3) p_state <= P_IDLE;
        end
        default: p_state <= P_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu_runner.sv
// Directed bench for uart_alu_runner: drives 8N1 packets on rx_i, decodes tx_o frames and
// compares them against hand-computed response bytes.
`timescale 1ns/1ps
module tb_uart_alu_runner;
  localparam int CLK_HZ = 10_000_000;
  localparam int BAUD   = 625_000;
  localparam int CPB    = 16;
  localparam int HALF   = 8;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic rx_i = 1'b1;
  logic tx_o;

  always #50 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_alu_runner #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk_i(clk), .reset_i(reset_i), .rx_i(rx_i), .tx_o(tx_o)
  );

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  logic [7:0] pl_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int t_mark = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- tx monitor ----------------
  logic [7:0] mon_b;
  int         mon_t;
  always begin
    @(negedge tx_o);
    if (!reset_i) begin
      mon_t = cyc;
      repeat (HALF) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 mon_b[i] = tx_o;
      end
      repeat (CPB) @(posedge clk);
      #1 check_eq("tx_stop_bit", {31'd0, tx_o}, 32'd1);
      got_q.push_back(mon_b);
      got_t.push_back(mon_t);
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop_v;
    repeat (HALF) @(negedge clk);
    t_mark = cyc;
    repeat (CPB - HALF) @(negedge clk);
    rx_i = 1'b1;
    if (!stop_v) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [15:0] len);
    send_byte(op, 1'b1);
    send_byte(8'h5E, 1'b1);
    send_byte(len[7:0], 1'b1);
    send_byte(len[15:8], 1'b1);
    foreach (pl_q[i]) send_byte(pl_q[i], 1'b1);
  endtask

  task automatic run_check(input string tag, input int lat_lim, input bit chk_gap);
    int n;
    n = exp_q.size();
    for (int c = 0; c < 1500 && got_q.size() < n; c++) @(posedge clk);
    repeat (200) @(posedge clk);
    check_eq({tag, "_count"}, got_q.size(), n);
    if (lat_lim > 0 && got_t.size() > 0)
      check_eq({tag, "_latency_ok"}, {31'd0, (got_t[0] - t_mark) <= lat_lim}, 32'd1);
    if (chk_gap)
      for (int i = 1; i < got_t.size(); i++)
        check_eq({tag, "_gap"}, got_t[i] - got_t[i-1], 32'd160);
    while (exp_q.size() > 0) begin
      if (got_q.size() > 0) check_eq({tag, "_byte"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
      else void'(exp_q.pop_front());
    end
    got_q.delete();
    got_t.delete();
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycles %0d limit 90000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(negedge clk);
    check_eq("reset_tx", {31'd0, tx_o}, 32'd1);
    reset_i = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("idle_tx", {31'd0, tx_o}, 32'd1);

    pl_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt(8'hA0, 16'd8);
    exp_q = '{8'h03, 8'h00, 8'h00, 8'h00};
    run_check("add", 44, 1'b1);

    pl_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt(8'hA0, 16'd8);
    exp_q = '{8'h01, 8'h00, 8'h00, 8'h00};
    run_check("add_wrap", 44, 1'b1);

    pl_q = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h03, 8'h00, 8'h01, 8'h00};
    send_pkt(8'hA1, 16'd8);
    exp_q = '{8'h00, 8'h00, 8'h03, 8'h00};
    run_check("mul", 44, 1'b1);

    pl_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00};
    send_pkt(8'hA2, 16'd8);
    exp_q = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_check("div", 84, 1'b1);

    // 1000 / 7 = 142 = 0x8E
    pl_q = '{8'hE8, 8'h03, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    send_pkt(8'hA2, 16'd8);
    exp_q = '{8'h8E, 8'h00, 8'h00, 8'h00};
    run_check("div_7", 84, 1'b1);

    pl_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(8'hA2, 16'd8);
    exp_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_check("div_zero", 84, 1'b1);

    pl_q = '{8'h5A, 8'hC3};
    send_pkt(8'hEC, 16'd2);
    exp_q = '{8'h5A, 8'hC3};
    run_check("echo", 0, 1'b0);
    repeat (2000) @(negedge clk);
    pl_q = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h01, 8'h01, 8'h01, 8'h01};
    send_pkt(8'hA0, 16'd8);
    exp_q = '{8'h45, 8'h34, 8'h23, 8'h12};
    run_check("add_after_echo", 44, 1'b1);

    pl_q = '{8'h01, 8'h02, 8'h03};
    send_pkt(8'h55, 16'd3);
    run_check("unknown_op", 0, 1'b0);

    pl_q.delete();
    send_pkt(8'hA0, 16'd0);
    run_check("len_zero", 0, 1'b0);

    // Glitch and framing-error byte must both vanish without disturbing the parser.
    @(negedge clk);
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    send_byte(8'hA0, 1'b0);
    pl_q = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h07};
    send_pkt(8'hA0, 16'd5);
    exp_q = '{8'h17, 8'h00, 8'h00, 8'h00};
    run_check("short_len", 44, 1'b1);

    pl_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    send_pkt(8'hA0, 16'd10);
    exp_q = '{8'h02, 8'h00, 8'h00, 8'h00};
    run_check("long_len", 0, 1'b1);

    pl_q = '{8'h01, 8'h02, 8'h03};
    send_pkt(8'hA0, 16'd8);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (40) @(negedge clk);
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
      end
    join
    repeat (100) @(negedge clk);
    check_eq("reset_abort_tx", {31'd0, tx_o}, 32'd1);
    run_check("reset_abort", 0, 1'b0);
    pl_q = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt(8'hA0, 16'd8);
    exp_q = '{8'h0C, 8'h00, 8'h00, 8'h00};
    run_check("add_after_reset", 44, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_alu_runner.md
UART_ALU_RUNNER -- requirements
Module: uart_alu_runner

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000, system clock frequency.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE, integer-truncated.
REQ-003 SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx_i  input  1  UART serial input, idle high, asynchronous to clk_i.
REQ-006 SHALL have port tx_o  output  1  UART serial output, idle high.

Function
REQ-007 SHALL use UART framing 8N1: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-008 SHALL pass rx_i through a 2-flop synchronizer before any use.
REQ-009 SHALL have the receiver detect a falling edge, confirm start bit low at mid-bit (CLKS_PER_BIT/2), then sample data and stop bits every CLKS_PER_BIT cycles.
REQ-010 SHALL return the receiver to idle without a byte if the start bit is high at mid-bit (glitch).
REQ-011 SHALL discard a received byte whose stop bit samples 0 (framing error); parser state unchanged.
REQ-012 SHALL parse packets as: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8], then LEN payload bytes.
REQ-013 SHALL implement parser states IDLE, RESERVED, LEN_LSB, LEN_MSB, PAYLOAD, COMPUTE, RESPOND; IDLE -> RESERVED on any received byte (latched as opcode).
REQ-014 SHALL, if LEN=0, go from LEN_MSB directly to IDLE with no response, for any opcode.
REQ-015 SHALL support opcode 0xEC ECHO: each payload byte is queued to the transmitter as received, in order; no header is sent.
REQ-016 SHALL queue echo bytes in a TX FIFO of at least 4 entries.
REQ-017 SHALL drop an echo byte that arrives with the FIFO full.
REQ-018 SHALL support ALU opcodes 0xA0 ADD, 0xA1 MUL, 0xA2 DIV, operating on unsigned 32-bit operands.
REQ-019 SHALL build ALU operands little-endian: A = {p3,p2,p1,p0}, B = {p7,p6,p5,p4}.
REQ-020 SHALL ignore payload bytes beyond index 7 for ALU opcodes.
REQ-021 SHALL treat missing operand bytes as 0 when LEN<8.
REQ-022 SHALL compute ADD = (A+B) mod 2^32; carry discarded.
REQ-023 SHALL compute MUL = low 32 bits of A*B.
REQ-024 SHALL compute DIV = floor(A/B) using an iterative restoring divider, at most 34 cycles.
REQ-025 SHALL return 0xFFFFFFFF for DIV when B=0.
REQ-026 SHALL enter COMPUTE after the last payload byte, and RESPOND when the result is ready.
REQ-027 SHALL, in RESPOND, send exactly 4 bytes, result LSB first: r[7:0], r[15:8], r[23:16], r[31:24].
REQ-028 SHALL start the first start bit within 40 clock cycles of the last payload byte being accepted for ADD/MUL, and within 80 cycles for DIV.
REQ-029 SHALL transmit the response bytes back-to-back, with no idle bits between frames.
REQ-030 SHALL return to IDLE after the 4th byte is queued.
REQ-031 SHALL, for unknown opcodes, consume and discard LEN payload bytes, send no response, then return to IDLE.
REQ-032 SHALL ignore bytes received during COMPUTE/RESPOND.
REQ-033 SHALL drive tx_o high whenever the transmitter is idle.

Reset
REQ-034 SHALL, on reset_i=1 at a clock edge, set: tx_o=1, parser IDLE, RX/TX idle, TX FIFO empty, counters, operands and result 0.
REQ-035 SHALL abort any in-progress frame or packet on reset mid-operation, with no partial response after release.
REQ-036 SHALL resume operation on the first clock edge with reset_i=0 and accept the next start bit.

Verification
REQ-037 SHALL pass: ADD, payload 01 00 00 00 02 00 00 00 -> tx bytes 03 00 00 00.
REQ-038 SHALL pass: ADD, A=0xFFFFFFFF, B=0x00000002 -> tx bytes 01 00 00 00 (wrap).
REQ-039 SHALL pass: MUL, A=0x00010000, B=0x00010003 -> tx bytes 00 00 03 00 (low 32 bits of 0x100030000).
REQ-040 SHALL pass: DIV, A=0x12345678, B=1 -> 78 56 34 12; DIV by B=0 -> FF FF FF FF.
REQ-041 SHALL pass: ECHO, LEN=2, payload 5A C3 -> tx bytes 5A C3 only; then an ADD packet 200 us later is answered correctly.
REQ-042 SHALL pass: opcode 0x55, LEN=3 -> no tx activity; reset asserted mid-payload -> tx_o stays 1 and the next valid packet is answered.
